// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// Pointer and valid/ready control that turns a simple single-clock dual-port RAM into a FWFT FIFO.
// Optional synchronous discard via flush_i is built only when MOR1KX_DPRAM_FIFO_FLUSH_EN is defined.
module mor1kx_dpram_fifo_ctrl #(
   parameter int DEPTH_WIDTH = 2,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [DATA_WIDTH-1:0]  push_data_i,
   output logic                   full_o,
   output logic                   pop_valid_o,
   input  logic                   pop_ready_i,
   output logic [DATA_WIDTH-1:0]  pop_data_o,
   output logic [DEPTH_WIDTH:0]   count_o,
   output logic [DEPTH_WIDTH-1:0] ram_waddr_o,
   output logic                   ram_we_o,
   output logic [DATA_WIDTH-1:0]  ram_din_o,
   output logic [DEPTH_WIDTH-1:0] ram_raddr_o,
   output logic                   ram_re_o,
   input  logic [DATA_WIDTH-1:0]  ram_dout_i,
   input  logic                   flush_i
);

   localparam logic [DEPTH_WIDTH:0] RAM_DEPTH = {1'b1, {DEPTH_WIDTH{1'b0}}};
   localparam logic [DEPTH_WIDTH:0] PTR_ONE   = {{DEPTH_WIDTH{1'b0}}, 1'b1};

   logic [DEPTH_WIDTH:0] wptr;
   logic [DEPTH_WIDTH:0] rptr;
   logic [DEPTH_WIDTH:0] ram_cnt;
   logic                 pop_valid;
   logic                 flush;
   logic                 push_ok;
   logic                 read_ok;

`ifdef MOR1KX_DPRAM_FIFO_FLUSH_EN
   assign flush = flush_i;
`else
   logic unused_flush;
   assign unused_flush = flush_i;
   assign flush        = 1'b0;
`endif

   // Extra pointer bit distinguishes full from empty without a separate flag.
   assign ram_cnt = wptr - rptr;
   assign full_o  = (ram_cnt == RAM_DEPTH);
   assign push_ok = push_i & ~full_o & ~flush;
   // Reading only when the output slot is free or draining keeps the RAM rdata register stable.
   assign read_ok = (ram_cnt != '0) & (~pop_valid | pop_ready_i) & ~flush;

   assign ram_we_o    = push_ok;
   assign ram_waddr_o = wptr[DEPTH_WIDTH-1:0];
   assign ram_din_o   = push_data_i;
   assign ram_re_o    = read_ok;
   assign ram_raddr_o = rptr[DEPTH_WIDTH-1:0];

   assign pop_valid_o = pop_valid;
   assign pop_data_o  = ram_dout_i;
   assign count_o     = ram_cnt + {{DEPTH_WIDTH{1'b0}}, pop_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         pop_valid <= 1'b0;
      end else if (flush) begin
         rptr      <= wptr;
         pop_valid <= 1'b0;
      end else begin
         if (push_ok)
            wptr <= wptr + PTR_ONE;
         if (read_ok)
            rptr <= rptr + PTR_ONE;
         if (read_ok)
            pop_valid <= 1'b1;
         else if (pop_ready_i)
            pop_valid <= 1'b0;
      end
   end

endmodule
